jacobi_seq_solver: RTL and testbench
====================================

// Module: jacobi_seq_solver
// PURPOSE
//  Iterative fixed-point solver for A*x=b (SIZE x SIZE) used by discrete-circuit nodal models.
//  Time-multiplexed: one multiplier, one sequential divider, so SIZE scales without DSP blow-up.
//  Selectable Jacobi / Gauss-Seidel update, runtime tolerance-based early exit,
//  max-iteration cap, singular-diagonal detection and a start/busy/done handshake.
// PARAMETERS
//  SIZE       3   matrix order (2..16)
//  PRECISION 16   integer bits of a sample word
//  POINT      8   fractional bits; word width W = PRECISION+POINT, signed Q(PRECISION.POINT)
//  ITER_W     8   width of max_iter / iter_count
// PORTS
//  clk        in   1          clock
//  I_RSTn     in   1          synchronous, active-low reset
//  start      in   1          1-cycle pulse; A, b, mode, tol, max_iter sampled this cycle
//  A          in   W [SIZE][SIZE]  coefficient matrix, signed Q format
//  b          in   W [SIZE]   right-hand side
//  mode       in   1          0 = Jacobi, 1 = Gauss-Seidel
//  tol        in   W          unsigned convergence threshold on max |x_new-x_old|
//  max_iter   in   ITER_W     sweep cap; 0 treated as 1
//  x          out  W [SIZE]   solution; held stable from done until next accepted start
//  busy       out  1          high from cycle after accepted start until done
//  done       out  1          1-cycle pulse at end of solve
//  converged  out  1          valid with done, held: 1 = tolerance met
//  singular   out  1          valid with done, held: 1 = some A[i][i]==0
//  iter_count out  ITER_W     sweeps executed, held
// BEHAVIOUR
//  Reset (any state, incl. mid-solve): FSM->IDLE; x=0, busy=0, done=0, converged=0,
//   singular=0, iter_count=0; divider/accumulators cleared. No done pulse for aborted solve.
//  start accepted only in IDLE/DONE; ignored while busy. Inputs copied to internal regs,
//   so A/b may change after start. x is reset to 0 at every accepted start (initial guess).
//  FSM: IDLE -> RECIP -> SWEEP -> CHECK -> (SWEEP | DONE) -> IDLE.
//  RECIP: per row i, Dinv[i] = (1<<2*POINT)/A[i][i], restoring divide on magnitudes,
//   1 setup + W quotient cycles = W+1 cycles/row; sign applied after; overflow saturates
//   to +/-(2^(W-1)-1). A[i][i]==0 -> singular=1, skip to DONE (converged=0, iter_count=0).
//  SWEEP row i: SIZE MAC cycles (j=0..SIZE-1, j==i adds 0), product 2W bits >>>POINT
//   (arith shift, floor), accumulator W+clog2(SIZE) bits; then 1 update cycle:
//   x_new = sat_W(((b[i]-acc) * Dinv[i]) >>> POINT). Row cost SIZE+1 cycles,
//   sweep SIZE*(SIZE+1) cycles.
//  Jacobi: x_new into shadow buffer; MACs read committed x; shadow committed to x in CHECK.
//  Gauss-Seidel: x[i] written in its update cycle; later rows of same sweep use it.
//  delta = max over i of |x_new[i]-x_old[i]| (W+1 bits, no wrap), cleared at sweep start.
//  CHECK (1 cycle): iter_count+=1; if delta<=tol -> DONE converged=1;
//   else if iter_count==max(max_iter,1) -> DONE converged=0; else next SWEEP.
//   Tolerance wins when both hold on the same sweep.
//  DONE: done=1 for one cycle, busy=0, go IDLE; flags/x held.
//  Total latency start->done = 1 + SIZE*(W+1) + k*(SIZE*(SIZE+1)+1) + 1, k = sweeps.
//  Saturation everywhere instead of wrap; divergent systems end by max_iter, never hang.
// TESTING
//  T1 SIZE=2,POINT=8: A=I (256 diag), b={512,-256}, tol=0, max_iter=10 -> x={512,-256},
//     converged=1, iter_count=2; done cycle matches latency formula with k=2.
//  T2 A={{1024,256},{256,768}}, b={256,512}, tol=1, Jacobi -> x within 1 LSB of {23,163},
//     converged=1; rerun mode=1 -> same x, iter_count strictly smaller than Jacobi.
//  T3 same system, tol=0, max_iter=3 -> done after 3 sweeps, converged=0, iter_count=3.
//  T4 A[1][1]=0 -> done after RECIP reaches row 1, singular=1, converged=0, x=0.
//  T5 start pulses while busy ignored (result identical to T2); I_RSTn low mid-SWEEP ->
//     next cycle busy=0, x=0, no done; fresh start afterwards solves T2 correctly.
//  T6 A diag=256, off-diag=-32767*256, b=max -> x saturates to +/-(2^23-1), no wrap,
//     done by max_iter with converged=0.

Source files
------------

// File: rtl/jacobi_seq_solver.sv
// rtl/jacobi_seq_solver.sv - time-multiplexed Jacobi / Gauss-Seidel fixed-point linear solver
//
// Solves A*x=b in signed Q(PRECISION.POINT). One shared multiplier serves both
// the row MACs and the row update. A bit-serial restoring divider builds the
// diagonal reciprocals before the first sweep.
// Ports:
//   clk, I_RSTn          clock, synchronous active-low reset
//   start                one-cycle request; A, b, mode, tol, max_iter captured with it
//   A, b                 coefficient matrix and right-hand side (signed Q)
//   mode                 0 = Jacobi, 1 = Gauss-Seidel
//   tol                  unsigned threshold on max |x_new - x_old| over a sweep
//   max_iter             sweep cap (0 behaves as 1)
//   x                    solution, held from done until the next accepted start
//   busy, done           solve in progress / one-cycle completion pulse
//   converged, singular  result flags, held after done
//   iter_count           sweeps executed, held after done
module jacobi_seq_solver #(
  parameter int SIZE      = 3,
  parameter int PRECISION = 16,
  parameter int POINT     = 8,
  parameter int ITER_W    = 8,
  localparam int W        = PRECISION + POINT
) (
  input  logic                     clk,
  input  logic                     I_RSTn,
  input  logic                     start,
  input  logic signed [W-1:0]      A [SIZE][SIZE],
  input  logic signed [W-1:0]      b [SIZE],
  input  logic                     mode,
  input  logic        [W-1:0]      tol,
  input  logic        [ITER_W-1:0] max_iter,
  output logic signed [W-1:0]      x [SIZE],
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic                     singular,
  output logic        [ITER_W-1:0] iter_count
);
  localparam int RW  = $clog2(SIZE);
  localparam int CLW = $clog2(SIZE + 1);
  localparam int DCW = $clog2(W + 1);
  localparam int AW  = W + RW;
  localparam int MW  = AW + 1;
  localparam int PW  = MW + W;
  localparam int W1  = W + 1;

  localparam logic signed [W-1:0]  SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  SMIN = -SMAX;
  localparam logic        [W-1:0]  UMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = -PMAX;
  localparam logic [W-1:0]   DIVIDEND = W'(1) << (2 * POINT);
  localparam logic [RW-1:0]  ROW_LAST = RW'(SIZE - 1);
  localparam logic [CLW-1:0] COL_UPD  = CLW'(SIZE);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(W);

  typedef enum logic [2:0] {S_IDLE, S_RECIP, S_SWEEP, S_CHECK, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [W-1:0]      a_q [SIZE][SIZE], a_d [SIZE][SIZE];
  logic signed [W-1:0]      b_q [SIZE], b_d [SIZE];
  logic signed [W-1:0]      x_q [SIZE], x_d [SIZE];
  logic signed [W-1:0]      xs_q [SIZE], xs_d [SIZE];
  logic signed [W-1:0]      dinv_q [SIZE], dinv_d [SIZE];
  logic                     mode_q, mode_d;
  logic        [W-1:0]      tol_q, tol_d;
  logic        [ITER_W-1:0] maxit_q, maxit_d, iter_q, iter_d;
  logic        [RW-1:0]     row_q, row_d;
  logic        [CLW-1:0]    col_q, col_d;
  logic        [DCW-1:0]    dcnt_q, dcnt_d;
  logic        [W-1:0]      rem_q, rem_d, quo_q, quo_d, den_q, den_d;
  logic                     neg_q, neg_d, conv_q, conv_d, sing_q, sing_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic        [W:0]        delta_q, delta_d;

  // Saturate to the symmetric range +/-(2^(W-1)-1) so negation never wraps.
  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > PMAX)      return SMAX;
    else if (v < PMIN) return SMIN;
    else               return v[W-1:0];
  endfunction

  // Restoring divider step on magnitudes: shift in next dividend bit, subtract if it fits.
  logic [W:0]   rem_sh;
  logic         rem_ge;
  logic [W-1:0] rem_nx, quo_nx, recip_mag;
  assign rem_sh    = {rem_q, quo_q[W-1]};
  assign rem_ge    = rem_sh >= {1'b0, den_q};
  assign rem_nx    = rem_ge ? W'(rem_sh - {1'b0, den_q}) : rem_sh[W-1:0];
  assign quo_nx    = {quo_q[W-2:0], rem_ge};
  assign recip_mag = (quo_nx > UMAX) ? UMAX : quo_nx;

  // Shared multiplier: A[i][j]*x[j] during MAC columns, (b[i]-acc)*Dinv[i] in the update column.
  logic [RW-1:0]        ci;
  logic                 upd;
  logic signed [MW-1:0] diff, mul_a;
  logic signed [W-1:0]  mul_b, prod_sat;
  logic signed [PW-1:0] prod;
  logic signed [W:0]    dx;
  logic        [W:0]    dx_abs;
  assign ci       = col_q[RW-1:0];
  assign upd      = (col_q == COL_UPD);
  assign diff     = MW'(b_q[row_q]) - MW'(acc_q);
  assign mul_a    = upd ? diff : MW'(a_q[row_q][ci]);
  assign mul_b    = upd ? dinv_q[row_q] : x_q[ci];
  assign prod     = PW'(mul_a) * PW'(mul_b);
  assign prod_sat = sat_w(prod >>> POINT);
  assign dx       = W1'(prod_sat) - W1'(x_q[row_q]);
  assign dx_abs   = dx[W] ? W1'(-dx) : W1'(dx);

  always_comb begin
    state_d = state_q;  a_d = a_q;      b_d = b_q;      x_d = x_q;
    xs_d    = xs_q;     dinv_d = dinv_q; mode_d = mode_q; tol_d = tol_q;
    maxit_d = maxit_q;  iter_d = iter_q; row_d = row_q;  col_d = col_q;
    dcnt_d  = dcnt_q;   rem_d = rem_q;   quo_d = quo_q;  den_d = den_q;
    neg_d   = neg_q;    conv_d = conv_q; sing_d = sing_q;
    acc_d   = acc_q;    delta_d = delta_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done    = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start) begin
          a_d     = A;
          b_d     = b;
          mode_d  = mode;
          tol_d   = tol;
          maxit_d = (max_iter == '0) ? ITER_W'(1) : max_iter;
          for (int i = 0; i < SIZE; i++) begin
            x_d[i]  = '0;
            xs_d[i] = '0;
          end
          iter_d  = '0;  conv_d = 1'b0; sing_d = 1'b0;
          row_d   = '0;  col_d  = '0;   dcnt_d = '0;
          acc_d   = '0;  delta_d = '0;
          state_d = S_RECIP;
        end
      end
      S_RECIP: begin
        busy = 1'b1;
        if (dcnt_q == '0) begin
          if (a_q[row_q][row_q] == '0) begin
            sing_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            neg_d  = a_q[row_q][row_q][W-1];
            den_d  = a_q[row_q][row_q][W-1] ? W'(-a_q[row_q][row_q]) : W'(a_q[row_q][row_q]);
            rem_d  = '0;
            quo_d  = DIVIDEND;
            dcnt_d = DCW'(1);
          end
        end else begin
          rem_d  = rem_nx;
          quo_d  = quo_nx;
          dcnt_d = dcnt_q + DCW'(1);
          if (dcnt_q == DIV_LAST) begin
            dinv_d[row_q] = neg_q ? -$signed(recip_mag) : $signed(recip_mag);
            dcnt_d = '0;
            if (row_q == ROW_LAST) begin
              row_d = '0; col_d = '0; acc_d = '0; delta_d = '0;
              state_d = S_SWEEP;
            end else begin
              row_d = row_q + RW'(1);
            end
          end
        end
      end
      S_SWEEP: begin
        busy = 1'b1;
        if (!upd) begin
          // Diagonal term contributes nothing; the other SIZE-1 terms cannot overflow AW bits.
          if (ci != row_q) acc_d = acc_q + AW'(prod_sat);
          col_d = col_q + CLW'(1);
        end else begin
          xs_d[row_q] = prod_sat;
          if (mode_q) x_d[row_q] = prod_sat;
          if (dx_abs > delta_q) delta_d = dx_abs;
          acc_d = '0;
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_CHECK;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_CHECK: begin
        busy   = 1'b1;
        x_d    = xs_q;
        iter_d = iter_q + ITER_W'(1);
        if (delta_q <= {1'b0, tol_q}) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_d == maxit_q) begin
          state_d = S_DONE;
        end else begin
          delta_d = '0;
          state_d = S_SWEEP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_q <= S_IDLE;
      for (int i = 0; i < SIZE; i++) begin
        b_q[i] <= '0; x_q[i] <= '0; xs_q[i] <= '0; dinv_q[i] <= '0;
        for (int j = 0; j < SIZE; j++) a_q[i][j] <= '0;
      end
      mode_q <= 1'b0; tol_q <= '0; maxit_q <= '0; iter_q <= '0;
      row_q  <= '0;   col_q <= '0; dcnt_q <= '0;
      rem_q  <= '0;   quo_q <= '0; den_q <= '0;  neg_q <= 1'b0;
      conv_q <= 1'b0; sing_q <= 1'b0;
      acc_q  <= '0;   delta_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;    b_q   <= b_d;   x_q <= x_d;  xs_q <= xs_d; dinv_q <= dinv_d;
      mode_q  <= mode_d; tol_q <= tol_d; maxit_q <= maxit_d; iter_q <= iter_d;
      row_q   <= row_d;  col_q <= col_d; dcnt_q <= dcnt_d;
      rem_q   <= rem_d;  quo_q <= quo_d; den_q <= den_d; neg_q <= neg_d;
      conv_q  <= conv_d; sing_q <= sing_d;
      acc_q   <= acc_d;  delta_q <= delta_d;
    end
  end

  assign x          = x_q;
  assign converged  = conv_q;
  assign singular   = sing_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_jacobi_seq_solver.sv
// tb/tb_jacobi_seq_solver.sv - directed self-checking bench for jacobi_seq_solver
module tb_jacobi_seq_solver;
  localparam int SIZE      = 2;
  localparam int PRECISION = 16;
  localparam int POINT     = 8;
  localparam int ITER_W    = 8;
  localparam int W         = PRECISION + POINT;
  localparam int RECIP_CYC = SIZE * (W + 1);
  localparam int SWEEP_CYC = SIZE * (SIZE + 1) + 1;
  localparam int VMAX      = 8388607;

  logic                     clk = 1'b0;
  logic                     I_RSTn;
  logic                     start;
  logic signed [W-1:0]      A [SIZE][SIZE];
  logic signed [W-1:0]      b [SIZE];
  logic                     mode;
  logic        [W-1:0]      tol;
  logic        [ITER_W-1:0] max_iter;
  logic signed [W-1:0]      x [SIZE];
  logic                     busy, done, converged, singular;
  logic        [ITER_W-1:0] iter_count;

  int checks = 0;
  int errors = 0;
  int lat, busy1, done_after, j_iter, gs_iter, ndone;

  always #5 clk = ~clk;

  jacobi_seq_solver #(.SIZE(SIZE), .PRECISION(PRECISION), .POINT(POINT), .ITER_W(ITER_W)) dut (
    .clk(clk), .I_RSTn(I_RSTn), .start(start), .A(A), .b(b), .mode(mode), .tol(tol),
    .max_iter(max_iter), .x(x), .busy(busy), .done(done), .converged(converged),
    .singular(singular), .iter_count(iter_count)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_sys(input int a00, input int a01, input int a10, input int a11,
                         input int b0, input int b1, input logic m, input int t, input int mi);
    A[0][0] = a00[W-1:0]; A[0][1] = a01[W-1:0];
    A[1][0] = a10[W-1:0]; A[1][1] = a11[W-1:0];
    b[0] = b0[W-1:0]; b[1] = b1[W-1:0];
    mode = m; tol = t[W-1:0]; max_iter = mi[ITER_W-1:0];
  endtask

  // Pulses start, then counts cycles after the start edge until done (bounded).
  // d0/d1 inject extra start pulses with different inputs while the solve runs.
  task automatic run(input int d0, input int d1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    busy1 = int'(busy);
    for (int n = 1; n <= 2000 && lat < 0; n++) begin
      if (n > 1) @(negedge clk);
      if (n == d0 || n == d1) begin
        set_sys(256, 0, 0, 256, 512, -256, 1'b1, 0, 10);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) lat = n;
    end
    start = 1'b0;
    @(negedge clk);
    done_after = int'(done);
  endtask

  initial begin
    I_RSTn = 1'b0;
    start  = 1'b0;
    set_sys(0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x0", x[0], 0);
    chk("rst_x1", x[1], 0);
    chk("rst_conv", converged, 0);
    chk("rst_sing", singular, 0);
    chk("rst_iter", iter_count, 0);
    I_RSTn = 1'b1;

    // T1: identity system converges in two sweeps
    set_sys(256, 0, 0, 256, 512, -256, 1'b0, 0, 10);
    run(0, 0);
    chk("t1_busy_cycle1", busy1, 1);
    chk("t1_latency", lat, RECIP_CYC + 2 * SWEEP_CYC + 1);
    chk("t1_done_one_cycle", done_after, 0);
    chk("t1_x0", x[0], 512);
    chk("t1_x1", x[1], -256);
    chk("t1_conv", converged, 1);
    chk("t1_iter", iter_count, 2);

    // T2: Jacobi then Gauss-Seidel on the 2x2 system [[4,1],[1,3]] x = [1,2]
    set_sys(1024, 256, 256, 768, 256, 512, 1'b0, 1, 10);
    run(0, 0);
    j_iter = int'(iter_count);
    chk("t2j_x0", x[0], 23);
    chk("t2j_x1", x[1], 162);
    chk("t2j_conv", converged, 1);
    chk("t2j_iter", iter_count, 5);
    chk("t2j_latency", lat, RECIP_CYC + 5 * SWEEP_CYC + 1);
    set_sys(1024, 256, 256, 768, 256, 512, 1'b1, 1, 10);
    run(0, 0);
    gs_iter = int'(iter_count);
    chk("t2gs_x0", x[0], 23);
    chk("t2gs_x1", x[1], 162);
    chk("t2gs_conv", converged, 1);
    chk("t2gs_iter", iter_count, 4);
    chk("t2_gs_fewer_sweeps", (gs_iter < j_iter), 1);

    // T3: iteration cap reached before tolerance
    set_sys(1024, 256, 256, 768, 256, 512, 1'b0, 0, 3);
    run(0, 0);
    chk("t3_latency", lat, RECIP_CYC + 3 * SWEEP_CYC + 1);
    chk("t3_conv", converged, 0);
    chk("t3_iter", iter_count, 3);
    chk("t3_x0", x[0], 27);
    chk("t3_x1", x[1], 163);

    // max_iter = 0 behaves as a single sweep
    set_sys(1024, 256, 256, 768, 256, 512, 1'b0, 0, 0);
    run(0, 0);
    chk("mi0_iter", iter_count, 1);
    chk("mi0_conv", converged, 0);
    chk("mi0_x0", x[0], 64);
    chk("mi0_x1", x[1], 170);

    // T4: zero on the diagonal of row 1
    set_sys(256, 0, 0, 0, 256, 256, 1'b0, 0, 10);
    run(0, 0);
    chk("t4_latency", lat, (W + 1) + 2);
    chk("t4_sing", singular, 1);
    chk("t4_conv", converged, 0);
    chk("t4_iter", iter_count, 0);
    chk("t4_x0", x[0], 0);
    chk("t4_x1", x[1], 0);

    // T5a: start pulses during RECIP and SWEEP are ignored
    set_sys(1024, 256, 256, 768, 256, 512, 1'b0, 1, 10);
    run(10, 60);
    chk("t5_x0", x[0], 23);
    chk("t5_x1", x[1], 162);
    chk("t5_iter", iter_count, 5);
    chk("t5_latency", lat, RECIP_CYC + 5 * SWEEP_CYC + 1);

    // T5b: reset in the middle of the second sweep aborts silently
    set_sys(1024, 256, 256, 768, 256, 512, 1'b0, 1, 10);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    I_RSTn = 1'b0;
    @(negedge clk);
    I_RSTn = 1'b1;
    chk("t5r_busy", busy, 0);
    chk("t5r_done", done, 0);
    chk("t5r_x0", x[0], 0);
    chk("t5r_x1", x[1], 0);
    ndone = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5r_no_done", ndone, 0);
    run(0, 0);
    chk("t5r_fresh_x0", x[0], 23);
    chk("t5r_fresh_x1", x[1], 162);
    chk("t5r_fresh_conv", converged, 1);

    // T6: divergent system oscillates between saturated values
    set_sys(256, -8388352, -8388352, 256, VMAX, -VMAX, 1'b0, 0, 3);
    run(0, 0);
    chk("t6_x0", x[0], VMAX);
    chk("t6_x1", x[1], -VMAX);
    chk("t6_conv", converged, 0);
    chk("t6_sing", singular, 0);
    chk("t6_iter", iter_count, 3);
    chk("t6_latency", lat, RECIP_CYC + 3 * SWEEP_CYC + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
